// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_if
//  Brief    : Requester/FIFO-side bundle for the round-robin write arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
  parameter int Num_req    = 4,
  parameter int Data_width = 8
);
  logic [Num_req-1:0]            req;
  logic [Num_req-1:0]            req_last;
  logic [Num_req*Data_width-1:0] req_data;
  logic                          fifo_full;
  logic [Num_req-1:0]            gnt;
  logic                          wr_en;
  logic [Data_width-1:0]         wr_data;
  logic                          busy;

  // Producer/FIFO side drives requests and the full flag.
  modport master (
    output req, req_last, req_data, fifo_full,
    input  gnt, wr_en, wr_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_last, req_data, fifo_full,
    output gnt, wr_en, wr_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Round-robin burst arbiter sharing one FIFO write port, full-gated.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int Num_req    = 4,
  parameter int Data_width = 8,
  parameter int Max_burst  = 8
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int c_ptr_w = $clog2(Num_req);
  localparam int c_cnt_w = $clog2(Max_burst) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(Max_burst - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_top  = c_ptr_w'(Num_req - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               r_state;
  logic [Num_req-1:0]   r_gnt;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [c_cnt_w-1:0]   r_cnt;

  state_t               w_state_nxt;
  logic [Num_req-1:0]   w_gnt_nxt;
  logic [c_ptr_w-1:0]   w_ptr_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;

  logic                 w_found;
  logic [c_ptr_w-1:0]   w_win_idx;
  logic [c_ptr_w-1:0]   w_gnt_idx;
  logic                 w_req_g;
  logic                 w_last_g;
  logic                 w_beat;
  logic                 w_end;
  logic [Data_width-1:0] w_wr_data;

  // Rotating priority search: walk downward so the index nearest ptr wins.
  always_comb begin : p_search
    int v_sum;
    logic [c_ptr_w-1:0] v_idx;
    v_sum     = 0;
    v_idx     = '0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = Num_req - 1; i >= 0; i--) begin
      v_sum = int'(r_ptr) + i;
      if (v_sum >= Num_req) begin
        v_sum = v_sum - Num_req;
      end
      v_idx = c_ptr_w'(v_sum);
      if (bus.req[v_idx]) begin
        w_found   = 1'b1;
        w_win_idx = v_idx;
      end
    end
  end

  always_comb begin : p_gnt_decode
    w_gnt_idx = '0;
    w_wr_data = '0;
    for (int i = 0; i < Num_req; i++) begin
      if (r_gnt[i]) begin
        w_gnt_idx = c_ptr_w'(i);
        w_wr_data = w_wr_data | bus.req_data[i*Data_width +: Data_width];
      end
    end
  end

  assign w_req_g  = |(r_gnt & bus.req);
  assign w_last_g = |(r_gnt & bus.req & bus.req_last);
  assign w_beat   = w_req_g & ~bus.fifo_full;
  // Abandon wins even while stalled; last/cutoff only count on an accepted beat.
  assign w_end    = ~w_req_g | (w_beat & (w_last_g | (r_cnt == c_cnt_last)));

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt           = BURST;
          w_gnt_nxt             = '0;
          w_gnt_nxt[w_win_idx]  = 1'b1;
          w_cnt_nxt             = '0;
        end
      end
      BURST: begin
        if (w_end) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (w_gnt_idx == c_ptr_top) ? '0 : w_gnt_idx + c_ptr_w'(1);
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin : p_regs
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.wr_en   = w_beat;
  assign bus.wr_data = w_wr_data;
  assign bus.busy    = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Brief    : Directed self-checking bench for the FIFO write-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   wr_total = 0;
  int   n0;

  fifo_wr_arbiter_if #(.Num_req(NREQ), .Data_width(DW)) bus ();

  fifo_wr_arbiter #(
    .Num_req    (NREQ),
    .Data_width (DW),
    .Max_burst  (MAXB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_total <= wr_total + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] g, input logic we, input logic bz);
    chk({tag, ".gnt"},   32'(bus.gnt),   32'(g));
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(we));
    chk({tag, ".busy"},  32'(bus.busy),  32'(bz));
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    bus.req_data[i*DW +: DW] = v;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    #3 rst = 1'b0;
    step();
    step();
    chk_st("reset", 4'b0000, 1'b0, 1'b0);
    chk("reset.wr_data", 32'(bus.wr_data), 32'h0);
    chk("reset.ptr", 32'(dut.r_ptr), 32'd0);
    rst = 1'b1;

    // Single burst on requester 2
    bus.req = 4'b0100;
    set_data(2, 8'hA0);
    #1;
    chk_st("t1.idle", 4'b0000, 1'b0, 1'b0);
    step();
    chk_st("t1.b0", 4'b0100, 1'b1, 1'b1);
    chk("t1.d0", 32'(bus.wr_data), 32'hA0);
    step();
    set_data(2, 8'hA1);
    #1;
    chk_st("t1.b1", 4'b0100, 1'b1, 1'b1);
    chk("t1.d1", 32'(bus.wr_data), 32'hA1);
    step();
    set_data(2, 8'hA2);
    bus.req_last = 4'b0100;
    #1;
    chk_st("t1.b2", 4'b0100, 1'b1, 1'b1);
    chk("t1.d2", 32'(bus.wr_data), 32'hA2);
    step();
    bus.req      = '0;
    bus.req_last = '0;
    #1;
    chk_st("t1.end", 4'b0000, 1'b0, 1'b0);
    chk("t1.ptr", 32'(dut.r_ptr), 32'd3);

    // Round-robin fairness from a fresh pointer
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t2.ptr_rst", 32'(dut.r_ptr), 32'd0);
    for (int i = 0; i < NREQ; i++) set_data(i, 8'(8'h10 + i));
    bus.req      = 4'b1111;
    bus.req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_st("t2.gnt", 4'(4'b0001 << (k % 4)), 1'b1, 1'b1);
      chk("t2.data", 32'(bus.wr_data), 32'(8'h10 + (k % 4)));
      step();
      chk_st("t2.gap", 4'b0000, 1'b0, 1'b0);
    end
    bus.req      = '0;
    bus.req_last = '0;
    chk("t2.ptr", 32'(dut.r_ptr), 32'd1);

    // Full stall in the middle of a 4-beat burst on requester 1
    bus.req = 4'b0010;
    set_data(1, 8'hB0);
    n0 = wr_total;
    step();
    chk_st("t3.b0", 4'b0010, 1'b1, 1'b1);
    chk("t3.d0", 32'(bus.wr_data), 32'hB0);
    step();
    set_data(1, 8'hB1);
    #1;
    chk_st("t3.b1", 4'b0010, 1'b1, 1'b1);
    chk("t3.d1", 32'(bus.wr_data), 32'hB1);
    step();
    set_data(1, 8'hB2);
    bus.fifo_full = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_st("t3.stall", 4'b0010, 1'b0, 1'b1);
      step();
    end
    bus.fifo_full = 1'b0;
    #1;
    chk_st("t3.b2", 4'b0010, 1'b1, 1'b1);
    chk("t3.d2", 32'(bus.wr_data), 32'hB2);
    step();
    set_data(1, 8'hB3);
    bus.req_last = 4'b0010;
    #1;
    chk_st("t3.b3", 4'b0010, 1'b1, 1'b1);
    chk("t3.d3", 32'(bus.wr_data), 32'hB3);
    step();
    bus.req      = '0;
    bus.req_last = '0;
    #1;
    chk_st("t3.end", 4'b0000, 1'b0, 1'b0);
    chk("t3.writes", 32'(wr_total - n0), 32'd4);
    chk("t3.ptr", 32'(dut.r_ptr), 32'd2);

    // Max-burst cutoff on requester 1 with no last
    bus.req = 4'b0010;
    n0 = wr_total;
    step();
    chk_st("t4.gnt", 4'b0010, 1'b1, 1'b1);
    for (int k = 0; k < MAXB; k++) begin
      set_data(1, 8'(8'hC0 + k));
      #1;
      chk("t4.we", 32'(bus.wr_en), 32'd1);
      chk("t4.data", 32'(bus.wr_data), 32'(8'hC0 + k));
      step();
    end
    chk_st("t4.cut", 4'b0000, 1'b0, 1'b0);
    chk("t4.writes", 32'(wr_total - n0), 32'd8);
    step();
    chk_st("t4.regnt", 4'b0010, 1'b1, 1'b1);
    bus.req = '0;
    step();
    chk_st("t4.aband", 4'b0000, 1'b0, 1'b0);
    chk("t4.ptr", 32'(dut.r_ptr), 32'd2);

    // Abandon: move ptr to 0 via requester 3, then req[0] drops after 2 beats
    bus.req      = 4'b1000;
    bus.req_last = 4'b1000;
    step();
    chk_st("t5.pre", 4'b1000, 1'b1, 1'b1);
    step();
    bus.req      = 4'b1001;
    bus.req_last = '0;
    set_data(0, 8'hD0);
    #1;
    chk_st("t5.idle", 4'b0000, 1'b0, 1'b0);
    chk("t5.ptr0", 32'(dut.r_ptr), 32'd0);
    step();
    chk_st("t5.b0", 4'b0001, 1'b1, 1'b1);
    chk("t5.d0", 32'(bus.wr_data), 32'hD0);
    step();
    set_data(0, 8'hD1);
    #1;
    chk_st("t5.b1", 4'b0001, 1'b1, 1'b1);
    chk("t5.d1", 32'(bus.wr_data), 32'hD1);
    step();
    bus.req = 4'b1000;
    #1;
    chk_st("t5.drop", 4'b0001, 1'b0, 1'b1);
    step();
    chk_st("t5.end", 4'b0000, 1'b0, 1'b0);
    chk("t5.ptr1", 32'(dut.r_ptr), 32'd1);
    step();
    chk_st("t5.next", 4'b1000, 1'b1, 1'b1);
    bus.req = '0;
    step();
    chk_st("t5.idle2", 4'b0000, 1'b0, 1'b0);

    // Reset during beat 2 of a burst on requester 2
    bus.req = 4'b0100;
    set_data(2, 8'hE0);
    step();
    chk_st("t6.gnt", 4'b0100, 1'b1, 1'b1);
    step();
    set_data(2, 8'hE1);
    rst = 1'b0;
    #1;
    chk_st("t6.rst", 4'b0000, 1'b0, 1'b0);
    chk("t6.wr_data", 32'(bus.wr_data), 32'h0);
    chk("t6.ptr", 32'(dut.r_ptr), 32'd0);
    bus.req = 4'b1111;
    step();
    chk_st("t6.hold", 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_st("t6.first", 4'b0001, 1'b1, 1'b1);
    bus.req = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the asynchronous FIFO's write side among several requesters, all in the write clock domain. It grants one requester at a time for a burst and muxes that requester's data onto the FIFO write port. It gates every write with the FIFO full flag, so no beat is lost or duplicated. It sits between the producer blocks and the FIFO `Wr_enable`/`data_in` inputs.

## Interface
- `Num_req`, 4: number of requesters; must be at least 2.
- `Data_width`, 8: FIFO data width.
- `Max_burst`, 8: maximum beats per grant; must be at least 1.
- `clk` input, 1: write-side clock; drive with the FIFO's `clk_write`.
- `rst` input, 1: asynchronous, active-low reset.
- `req` input, `Num_req`: per-requester request / data-valid.
- `req_last` input, `Num_req`: final beat of the requester's burst; qualified by `req`.
- `req_data` input, `Num_req*Data_width`: requester i data occupies bits `[i*Data_width +: Data_width]`.
- `fifo_full` input, 1: FIFO full flag, already in the `clk` domain.
- `gnt` output, `Num_req`: registered one-hot grant; all zero when idle.
- `wr_en` output, 1: FIFO write enable, one per accepted beat.
- `wr_data` output, `Data_width`: FIFO write data.
- `busy` output, 1: high while in BURST.

## Operation
- **States:** IDLE and BURST. Registered state consists of `state`, `gnt`, the priority pointer `ptr` (`$clog2(Num_req)` bits) and the beat counter `cnt` (`$clog2(Max_burst)+1` bits).
- **IDLE:**
  - Search `req` starting at index `ptr`, wrapping modulo `Num_req`. The first set bit is the winner.
  - At the next edge: `gnt` becomes one-hot of the winner, `cnt` is 0, state goes to BURST.
  - If no requests, stay in IDLE.
- **Beat acceptance:** `beat = |(gnt & req) & ~fifo_full`. This is combinational.
  - `wr_en = beat`.
  - `wr_data` is the granted requester's slice of `req_data`, and is 0 when `gnt` is all zero.
- **BURST:** each accepted beat increments `cnt`. The burst ends at the edge where any of these holds:
  - (a) `beat` and `req_last[g]`;
  - (b) `beat` and `cnt == Max_burst-1` (forced cutoff);
  - (c) `req[g]` is low (abandon; no beat occurs).
- **On burst end:** `gnt` goes to 0, `cnt` goes to 0, state goes to IDLE, and `ptr` becomes `(g+1) mod Num_req`.
- **Full stall:** while `fifo_full` is high in BURST, `gnt` is held, `wr_en` is 0, `cnt` does not change and the burst does not end. Case (c) still applies during a stall.
- **Other requests:** changes on non-granted `req` lines during BURST are ignored.
- **Reset values** (asynchronous on `rst` = 0):
  - state IDLE, `gnt` = 0, `ptr` = 0, `cnt` = 0;
  - `busy` = 0, `wr_en` = 0, `wr_data` = 0.
  - A reset mid-burst discards the burst immediately, and no `wr_en` is asserted during reset.

## Timing
- **Grant latency:** a request sampled at edge t in IDLE gives `gnt` high after edge t. The first beat can be written at edge t+1.
- **Throughput:** one beat per cycle while `req[g]` is high and `fifo_full` is low. `wr_en` and `wr_data` are valid in the same cycle as the beat and are consumed by the FIFO at the same edge.
- **Burst gap:** if the last beat is at edge k, IDLE occupies cycle k+1 and the next `gnt` rises after edge k+1. There is exactly one dead cycle between bursts.
- **Full flag:** `fifo_full` acts combinationally on `wr_en` within the cycle. It has no registered lag inside this block.
- **Maximum burst:** a burst lasts at most `Max_burst` beats, plus any number of stall cycles.

## Test plan
- **Single burst:** only `req[2]` high, data 0xA0, 0xA1, 0xA2, with `req_last` on the third beat. Required response:
  - `gnt` = 4'b0100 one cycle later;
  - three `wr_en` pulses carrying 0xA0..0xA2;
  - `gnt` = 0 and `busy` = 0 after the third beat, `ptr` = 3.
- **Round-robin fairness:** all four `req` held high, `req_last` high on every beat. Grants occur in the order 0, 1, 2, 3, 0, with one beat each and one idle cycle between grants.
- **Full stall:** `fifo_full` high for 3 cycles in the middle of a 4-beat burst. Required response:
  - `wr_en` low during the stall, `gnt` held;
  - exactly 4 writes total, in order, with no duplicate.
- **Max-burst cutoff:** with `Max_burst` = 8, `req[1]` is held with no `req_last`. Required response:
  - exactly 8 `wr_en` pulses, then `gnt` drops;
  - `req[1]` is re-granted after the one idle cycle if it is the only requester.
- **Abandon:** `req[0]` drops after 2 beats with no `req_last`. Burst ends at that edge, `ptr` = 1, and `req[3]` (pending) is granted next.
- **Reset mid-burst:** `rst` low during beat 2 of a burst. `gnt`, `wr_en` and `busy` go to 0 immediately. After release with all requests high, requester 0 is granted first.
